// File: rtl/dsp_pkg.sv
// Shared definitions for the MAC pipeline: OP bit positions, group FSM
// encoding and the overflow clamp selector.
package dsp_pkg;

    localparam int OP_W        = 4;
    localparam int OP_PRE_EN   = 0;
    localparam int OP_PRE_SUB  = 1;
    localparam int OP_POST_SUB = 2;
    localparam int OP_ADD_C    = 3;

    typedef enum logic {
        ST_FIRST = 1'b0,
        ST_ACCUM = 1'b1
    } grp_state_e;

    typedef enum logic [1:0] {
        SAT_NONE = 2'd0,
        SAT_MAX  = 2'd1,
        SAT_MIN  = 2'd2
    } sat_e;

    // Signed overflow needs both addends of one sign, so the base operand's
    // sign bit tells which rail was crossed.
    function automatic sat_e sat_sel(input logic ovf, input logic is_signed, input logic base_msb);
        sat_e r;
        r = SAT_NONE;
        if (ovf) begin
            if (!is_signed) r = SAT_MAX;
            else            r = base_msb ? SAT_MIN : SAT_MAX;
        end
        return r;
    endfunction

endpackage

// File: rtl/dsp_premult_pipe.sv
// Front half of the MAC: input register, pre-adder, multiplier and optional
// post-multiply registers. Every stage freezes while stall is high.
module dsp_premult_pipe
    import dsp_pkg::*;
#(
    parameter int AW        = 18,
    parameter int BW        = 18,
    parameter int PW        = 48,
    parameter int MULT_PIPE = 1,
    parameter int SIGNED    = 1,
    parameter int SBW       = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            in_valid,
    input  logic [AW-1:0]   a,
    input  logic [BW-1:0]   b,
    input  logic [BW-1:0]   d,
    input  logic [OP_W-1:0] op,
    input  logic [SBW-1:0]  sb,
    output logic            out_valid,
    output logic [PW-1:0]   term,
    output logic            out_add_c,
    output logic [SBW-1:0]  out_sb
);

    localparam int XW     = BW + 1;
    localparam int MW     = AW + BW + 1;
    localparam int STAGES = 2 + MULT_PIPE;

    logic [STAGES:0]     vld_pipe;

    logic [AW-1:0]       a0;
    logic [BW-1:0]       b0, d0;
    logic [OP_W-1:0]     op0;
    logic [SBW-1:0]      sb0;

    // Past the pre-adder only {ADD_C, POST_SUB} still matter.
    logic [AW-1:0]       a1;
    logic [XW-1:0]       x1;
    logic [1:0]          op1;
    logic [SBW-1:0]      sb1;

    logic [MULT_PIPE:0][MW-1:0]  m_pipe;
    logic [MULT_PIPE:0][1:0]     op_pipe;
    logic [MULT_PIPE:0][SBW-1:0] sb_pipe;

    logic [XW-1:0] b_x, d_x, x_nxt;
    logic [MW-1:0] a_m, x_m, m_nxt, m_last;
    logic [PW-1:0] m_ext;
    logic          sa, sx, sm;

    always_comb begin
        b_x   = {(SIGNED != 0) & b0[BW-1], b0};
        d_x   = {(SIGNED != 0) & d0[BW-1], d0};
        x_nxt = b_x;
        if (op0[OP_PRE_EN]) x_nxt = op0[OP_PRE_SUB] ? (d_x - b_x) : (d_x + b_x);
    end

    // Low MW bits of the extended-operand product are the exact product.
    always_comb begin
        sa    = (SIGNED != 0) & a1[AW-1];
        sx    = (SIGNED != 0) & x1[XW-1];
        a_m   = {{(MW-AW){sa}}, a1};
        x_m   = {{(MW-XW){sx}}, x1};
        m_nxt = a_m * x_m;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            a0 <= '0; b0 <= '0; d0 <= '0; op0 <= '0; sb0 <= '0;
            a1 <= '0; x1 <= '0; op1 <= '0; sb1 <= '0;
            m_pipe <= '0; op_pipe <= '0; sb_pipe <= '0;
        end else if (!stall) begin
            vld_pipe   <= {vld_pipe[STAGES-1:0], in_valid};
            a0 <= a; b0 <= b; d0 <= d; op0 <= op; sb0 <= sb;
            a1 <= a0; x1 <= x_nxt; op1 <= {op0[OP_ADD_C], op0[OP_POST_SUB]}; sb1 <= sb0;
            m_pipe[0]  <= m_nxt;
            op_pipe[0] <= op1;
            sb_pipe[0] <= sb1;
            for (int i = 1; i <= MULT_PIPE; i++) begin
                m_pipe[i]  <= m_pipe[i-1];
                op_pipe[i] <= op_pipe[i-1];
                sb_pipe[i] <= sb_pipe[i-1];
            end
        end
    end

    assign m_last = m_pipe[MULT_PIPE];
    assign sm     = (SIGNED != 0) & m_last[MW-1];

    generate
        if (PW >= MW) begin : g_ext
            assign m_ext = {{(PW-MW){sm}}, m_last};
        end else begin : g_trunc
            assign m_ext = m_last[PW-1:0];
        end
    endgenerate

    assign out_valid = vld_pipe[STAGES];
    assign term      = op_pipe[MULT_PIPE][0] ? (-m_ext) : m_ext;
    assign out_add_c = op_pipe[MULT_PIPE][1];
    assign out_sb    = sb_pipe[MULT_PIPE];

endmodule

// File: rtl/dsp_mac_pipe.sv
// Pipelined pre-add/multiply/accumulate engine with valid/ready handshake,
// per-group dot-product accumulation, overflow reporting and optional clamp.
module dsp_mac_pipe
    import dsp_pkg::*;
#(
    parameter int AW        = 18,
    parameter int BW        = 18,
    parameter int PW        = 48,
    parameter int MULT_PIPE = 1,
    parameter int SIGNED    = 1,
    parameter int SATURATE  = 0,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [AW-1:0]    a,
    input  logic [BW-1:0]    b,
    input  logic [BW-1:0]    d,
    input  logic [PW-1:0]    c,
    input  logic [OP_W-1:0]  op,
    input  logic [CNT_W-1:0] acc_len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PW-1:0]    p,
    output logic             ovf
);

    localparam int SBW = CNT_W + PW;
    localparam logic [PW-1:0] P_MAX = (SIGNED != 0) ? {1'b0, {(PW-1){1'b1}}} : {PW{1'b1}};
    localparam logic [PW-1:0] P_MIN = (SIGNED != 0) ? {1'b1, {(PW-1){1'b0}}} : {PW{1'b0}};

    grp_state_e       state, state_nxt;
    logic             stall, advance, first, last, emit;
    logic             s3_valid, s3_add_c;
    logic [PW-1:0]    s3_term, s3_c;
    logic [SBW-1:0]   s3_sb;
    logic [CNT_W-1:0] s3_len, len_m1, cnt, cnt_nxt;
    logic [PW-1:0]    acc, base, raw, sum;
    logic [PW:0]      sum_w;
    logic             sticky, sticky_nxt, ovf_now;
    sat_e             sat;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    dsp_premult_pipe #(
        .AW(AW), .BW(BW), .PW(PW), .MULT_PIPE(MULT_PIPE), .SIGNED(SIGNED), .SBW(SBW)
    ) u_front (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .d         (d),
        .op        (op),
        .sb        ({acc_len, c}),
        .out_valid (s3_valid),
        .term      (s3_term),
        .out_add_c (s3_add_c),
        .out_sb    (s3_sb)
    );

    assign s3_c   = s3_sb[PW-1:0];
    assign s3_len = s3_sb[PW +: CNT_W];

    // Accumulate datapath: the group base is C (or 0) on the first beat,
    // the running sum afterwards.
    always_comb begin
        first   = (state == ST_FIRST);
        advance = s3_valid & ~stall;
        len_m1  = (s3_len == '0) ? '0 : (s3_len - CNT_W'(1));
        last    = first ? (len_m1 == '0) : (cnt == CNT_W'(1));
        base    = first ? (s3_add_c ? s3_c : '0) : acc;
        sum_w   = {1'b0, base} + {1'b0, s3_term};
        raw     = sum_w[PW-1:0];
        if (SIGNED != 0) ovf_now = (base[PW-1] == s3_term[PW-1]) && (raw[PW-1] != base[PW-1]);
        else             ovf_now = sum_w[PW];
        sat = (SATURATE != 0) ? sat_sel(ovf_now, SIGNED != 0, base[PW-1]) : SAT_NONE;
        case (sat)
            SAT_MAX: sum = P_MAX;
            SAT_MIN: sum = P_MIN;
            default: sum = raw;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_FIRST;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (advance) state_nxt = last ? ST_FIRST : ST_ACCUM;
    end

    always_comb begin
        emit       = advance & last;
        sticky_nxt = (first ? 1'b0 : sticky) | ovf_now;
        cnt_nxt    = first ? len_m1 : (cnt - CNT_W'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            sticky    <= 1'b0;
            out_valid <= 1'b0;
            p         <= '0;
            ovf       <= 1'b0;
        end else begin
            if (advance) begin
                cnt <= cnt_nxt;
                if (emit) begin
                    acc    <= '0;
                    sticky <= 1'b0;
                    p      <= sum;
                    ovf    <= sticky_nxt;
                end else begin
                    acc    <= sum;
                    sticky <= sticky_nxt;
                end
            end
            if (emit)                       out_valid <= 1'b1;
            else if (out_valid & out_ready) out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Directed bench for dsp_mac_pipe: a group-level arithmetic model checks every
// output handshake, and literal expectations pin each directed scenario.
module tb_dsp_mac_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, out_ready = 1'b1, v20 = 1'b0;
    logic [17:0] a = '0, b = '0, d = '0;
    logic [47:0] c = '0;
    logic [19:0] c20 = '0;
    logic [3:0]  op = '0;
    logic [7:0]  acc_len = '0;
    logic        in_ready, out_valid, ovf;
    logic [47:0] p;
    logic        ir_s, ov_s, ovf_s, ir_w, ov_w, ovf_w;
    logic [19:0] p_s, p_w;

    int n_pass = 0, n_total = 0, n_out = 0;

    always #5 clk = ~clk;

    dsp_mac_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .d(d), .c(c), .op(op), .acc_len(acc_len),
        .out_valid(out_valid), .out_ready(out_ready), .p(p), .ovf(ovf));

    dsp_mac_pipe #(.PW(20), .SATURATE(1)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(v20), .in_ready(ir_s),
        .a(a), .b(b), .d(d), .c(c20), .op(op), .acc_len(acc_len),
        .out_valid(ov_s), .out_ready(1'b1), .p(p_s), .ovf(ovf_s));

    dsp_mac_pipe #(.PW(20), .SATURATE(0)) dut_wrap (
        .clk(clk), .rst(rst), .in_valid(v20), .in_ready(ir_w),
        .a(a), .b(b), .d(d), .c(c20), .op(op), .acc_len(acc_len),
        .out_valid(ov_w), .out_ready(1'b1), .p(p_w), .ovf(ovf_w));

    task automatic chk(input string nm, input longint act, input longint exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // Group model: plain integer dot product, wrapped to 48-bit signed.
    localparam longint MAX48 = (64'sd1 <<< 47) - 1;
    localparam longint MIN48 = -(64'sd1 <<< 47);
    longint q_p[$];
    bit     q_o[$];
    bit     m_first = 1'b1, m_ovf = 1'b0, stall_prev = 1'b0;
    longint m_sum = 0, p_prev = 0;
    int     m_rem = 0;

    always @(negedge clk) begin : model
        longint xa, xb, xd, xx, t;
        if (rst) begin
            q_p.delete(); q_o.delete();
            m_first = 1'b1; m_sum = 0; m_ovf = 1'b0; stall_prev = 1'b0;
        end else begin
            chk("in_ready_rule", longint'(in_ready), longint'(!(out_valid && !out_ready)));
            if (stall_prev) begin
                chk("stall_valid_hold", longint'(out_valid), 1);
                chk("stall_p_hold", longint'(p), p_prev);
            end
            stall_prev = out_valid && !out_ready;
            p_prev     = longint'(p);
            if (out_valid && out_ready) begin
                n_out++;
                chk("out_pending", longint'(q_p.size() > 0), 1);
                if (q_p.size() > 0) begin
                    chk("model_p", longint'($signed(p)), q_p.pop_front());
                    chk("model_ovf", longint'(ovf), longint'(q_o.pop_front()));
                end
            end
            if (in_valid && in_ready) begin
                xa = longint'($signed(a));
                xb = longint'($signed(b));
                xd = longint'($signed(d));
                xx = op[0] ? (op[1] ? xd - xb : xd + xb) : xb;
                t  = xa * xx;
                if (op[2]) t = -t;
                if (m_first) begin
                    m_sum = op[3] ? longint'($signed(c)) : 0;
                    m_ovf = 1'b0;
                    m_rem = (acc_len == 0) ? 1 : int'(acc_len);
                end
                m_sum = m_sum + t;
                if (m_sum > MAX48 || m_sum < MIN48) begin
                    m_ovf = 1'b1;
                    m_sum = (m_sum <<< 16) >>> 16;
                end
                m_rem--;
                m_first = (m_rem == 0);
                if (m_first) begin
                    q_p.push_back(m_sum);
                    q_o.push_back(m_ovf);
                end
            end
        end
    end

    task automatic send(input logic [17:0] ia, ib, id, input logic [47:0] ic,
                        input logic [3:0] iop, input logic [7:0] ilen);
        int n;
        a = ia; b = ib; d = id; c = ic; op = iop; acc_len = ilen; in_valid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!in_ready && n < 100);
        chk("send_accept", longint'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string nm, input longint exp_p, input logic exp_o);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 30);
        chk({nm, "_valid"}, longint'(out_valid), 1);
        chk({nm, "_p"}, longint'($signed(p)), exp_p);
        chk({nm, "_ovf"}, longint'(ovf), longint'(exp_o));
        @(posedge clk); #1;
    endtask

    initial begin
        int n, n0, seen;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_p", longint'(p), 0);
        chk("rst_ovf", longint'(ovf), 0);
        chk("rst_in_ready", longint'(in_ready), 1);
        chk("rst_sat_p", longint'(p_s), 0);
        chk("rst_sat_in_ready", longint'(ir_s & ir_w), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk); #1;

        // single term, latency
        send(18'd3, -18'sd5, 18'd0, 48'd0, 4'b0000, 8'd1);
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 20);
        chk("t1_latency", n, 5);
        chk("t1_p", longint'($signed(p)), -15);
        chk("t1_ovf", longint'(ovf), 0);
        @(posedge clk); #1;

        // four-term group with C offset on first beat only
        send(18'd1, 18'd2, 18'd0, 48'd100, 4'b1000, 8'd4);
        send(18'd3, 18'd4, 18'd0, 48'd999, 4'b1000, 8'd9);
        send(18'd5, 18'd6, 18'd0, 48'd0,   4'b0000, 8'd0);
        send(18'd7, 18'd8, 18'd0, 48'd0,   4'b0000, 8'd0);
        wait_result("t2", 200, 1'b0);

        // pre-subtract, then with post-negate
        send(18'd7, 18'd4, 18'd10, 48'd0, 4'b0011, 8'd1);
        send(18'd7, 18'd4, 18'd10, 48'd0, 4'b0111, 8'd1);
        wait_result("t3a", 42, 1'b0);
        wait_result("t3b", -42, 1'b0);

        // backpressure: five single-term groups while the sink stalls
        n0 = n_out;
        out_ready = 1'b0;
        fork
            begin
                send(18'd2,  18'd3,  18'd0, 48'd0, 4'b0000, 8'd1);
                send(18'd4,  18'd5,  18'd0, 48'd0, 4'b0000, 8'd1);
                send(18'd6,  18'd7,  18'd0, 48'd0, 4'b0000, 8'd1);
                send(18'd8,  18'd9,  18'd0, 48'd0, 4'b0000, 8'd1);
                send(18'd10, 18'd11, 18'd0, 48'd0, 4'b0000, 8'd1);
            end
            begin
                repeat (14) @(posedge clk);
                @(negedge clk);
                chk("t4_in_ready_low", longint'(in_ready), 0);
                chk("t4_held_valid", longint'(out_valid), 1);
                chk("t4_held_p", longint'($signed(p)), 6);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        repeat (15) @(posedge clk); #1;
        chk("t4_results_out", n_out - n0, 5);

        // 20-bit saturate vs wrap, 600*600 twice
        a = 18'd600; b = 18'd600; d = '0; op = 4'b0000; acc_len = 8'd2; v20 = 1'b1;
        repeat (2) @(posedge clk); #1;
        v20 = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!ov_s && n < 20);
        chk("t5_valid", longint'(ov_s & ov_w), 1);
        chk("t5_sat_p", longint'($signed(p_s)), 524287);
        chk("t5_sat_ovf", longint'(ovf_s), 1);
        chk("t5_wrap_p", longint'($signed(p_w)), -328576);
        chk("t5_wrap_ovf", longint'(ovf_w), 1);
        @(posedge clk); #1;

        // reset in the middle of a group
        send(18'd1, 18'd1, 18'd0, 48'd0, 4'b0000, 8'd4);
        send(18'd1, 18'd1, 18'd0, 48'd0, 4'b0000, 8'd4);
        rst = 1'b1;
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        repeat (12) begin @(negedge clk); seen = seen | int'(out_valid); end
        chk("t6_no_output", seen, 0);
        @(posedge clk); #1;
        send(18'd2, 18'd2, 18'd0, 48'd0, 4'b0000, 8'd1);
        wait_result("t6", 4, 1'b0);

        repeat (5) @(posedge clk);
        chk("model_drained", q_p.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
